// File: rtl/cake_field.sv
// rtl/cake_field.sv - falling-cake field: per-frame position sweep, LFSR respawn, per-pixel hit flags
module cake_field #(
    parameter int          N_CAKES   = 101,
    parameter int          CAKE_W    = 8,
    parameter int          CAKE_H    = 8,
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          FALL_STEP = 2,
    parameter int          SPAWN_DIV = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [9:0]         xLength,
    input  logic [9:0]         yLength,
    input  logic               frame_tick,
    input  logic               freeze,
    output logic [N_CAKES-1:0] cake,
    output logic               busy,
    output logic [6:0]         active_count
);
    localparam int IW = (N_CAKES > 1) ? $clog2(N_CAKES) : 1;
    localparam int FW = (SPAWN_DIV > 1) ? $clog2(SPAWN_DIV) : 1;

    localparam logic [0:0]    S_IDLE  = 1'b0;
    localparam logic [0:0]    S_SWEEP = 1'b1;
    localparam logic [IW-1:0] LAST    = IW'(N_CAKES - 1);
    localparam logic [FW-1:0] FLAST   = FW'(SPAWN_DIV - 1);
    localparam logic [9:0]    X_MAX   = 10'(H_ACTIVE - CAKE_W);

    logic [0:0]         state;
    logic [N_CAKES-1:0] act;
    logic [9:0]         xs [N_CAKES];
    logic [9:0]         ys [N_CAKES];
    logic [15:0]        lfsr;
    logic [FW-1:0]      fcnt;
    logic [IW-1:0]      idx;
    logic               tok;
    logic [9:0]         spawn_x;
    logic [10:0]        y_next;
    logic [6:0]         pop;

    // Values above X_MAX fold back by 512, which always lands on-screen since X_MAX >= 512.
    assign spawn_x = (lfsr[9:0] > X_MAX) ? (lfsr[9:0] - 10'd512) : lfsr[9:0];
    assign y_next  = {1'b0, ys[idx]} + 11'(FALL_STEP);

    always_comb begin
        cake = '0;
        for (int i = 0; i < N_CAKES; i++) begin
            cake[i] = act[i]
                && ({1'b0, xs[i]} <= {1'b0, xLength})
                && ({1'b0, xLength} < ({1'b0, xs[i]} + 11'(CAKE_W)))
                && ({1'b0, ys[i]} <= {1'b0, yLength})
                && ({1'b0, yLength} < ({1'b0, ys[i]} + 11'(CAKE_H)));
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CAKES; i++) begin
            pop = pop + 7'(act[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            act          <= '0;
            for (int i = 0; i < N_CAKES; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
            lfsr         <= LFSR_SEED;
            fcnt         <= '0;
            idx          <= '0;
            tok          <= 1'b0;
            busy         <= 1'b0;
            active_count <= '0;
        end else begin
            active_count <= pop;
            case (state)
                S_IDLE: begin
                    if (frame_tick && !freeze) begin
                        fcnt  <= (fcnt == FLAST) ? '0 : fcnt + 1'b1;
                        tok   <= (fcnt == FLAST);
                        lfsr  <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
                        idx   <= '0;
                        state <= S_SWEEP;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    // The token goes to the first inactive slot visited, i.e. the lowest index.
                    if (act[idx]) begin
                        if (y_next >= 11'(V_ACTIVE)) begin
                            act[idx] <= 1'b0;
                        end else begin
                            ys[idx] <= y_next[9:0];
                        end
                    end else if (tok) begin
                        act[idx] <= 1'b1;
                        ys[idx]  <= '0;
                        xs[idx]  <= spawn_x;
                        tok      <= 1'b0;
                    end
                    if (idx == LAST) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        tok   <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cake_field.sv
// tb/tb_cake_field.sv - scoreboard bench for cake_field
module tb_cake_field;
    localparam int N  = 101;
    localparam int X0 = 78;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [9:0]   xLength = '0;
    logic [9:0]   yLength = '0;
    logic         frame_tick = 1'b0;
    logic         freeze = 1'b0;
    logic [N-1:0] cake;
    logic         busy;
    logic [6:0]   active_count;

    cake_field dut (
        .clk(clk), .rst(rst), .xLength(xLength), .yLength(yLength),
        .frame_tick(frame_tick), .freeze(freeze),
        .cake(cake), .busy(busy), .active_count(active_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int slot;
        int exp;
        int tag;
    } probe_t;

    probe_t pq[$];
    int     sq[$];
    int     tests = 0;
    int     fails = 0;
    logic   strobe = 1'b0;
    int     tag = 0;

    bit mact [N];
    int mx [N];
    int my [N];
    int mlfsr, mfcnt, last_spawn;
    bit mtok;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mact[i] = 0; mx[i] = 0; my[i] = 0;
        end
        mlfsr = 16'hACE1; mfcnt = 0; mtok = 0; last_spawn = -1;
    endfunction

    function automatic void model_sweep();
        int v;
        mtok  = (mfcnt == 3);
        mfcnt = mtok ? 0 : mfcnt + 1;
        mlfsr = (mlfsr & 1) ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
        for (int i = 0; i < N; i++) begin
            if (mact[i]) begin
                if (my[i] + 2 >= 480) mact[i] = 0;
                else my[i] = my[i] + 2;
            end else if (mtok) begin
                v = mlfsr & 16'h03FF;
                mact[i] = 1; my[i] = 0; mtok = 0; last_spawn = i;
                mx[i] = (v > 632) ? v - 512 : v;
            end
        end
        mtok = 0;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(mact[i]);
        return c;
    endfunction

    function automatic string kname(int k);
        case (k)
            1:       return "cake_bit";
            2:       return "active_count";
            3:       return "busy";
            default: return "cake_any";
        endcase
    endfunction

    // Monitor: busy-length per sweep from sq, strobed pixel/status probes from pq.
    int     bcnt = 0;
    bit     prev_busy = 0;
    int     exp_len;
    int     got;
    probe_t p;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            bcnt++;
        end else if (prev_busy) begin
            tests++;
            if (sq.size() == 0) begin
                fails++;
                $display("FAIL sweep_len unexpected sweep: got=%0d cycles required=no sweep", bcnt);
            end else begin
                exp_len = sq.pop_front();
                if (bcnt != exp_len) begin
                    fails++;
                    $display("FAIL sweep_len got=%0d required=%0d", bcnt, exp_len);
                end
            end
            bcnt = 0;
        end
        prev_busy = (busy === 1'b1);
        if (strobe) begin
            tests++;
            if (pq.size() == 0) begin
                fails++;
                $display("FAIL probe_queue empty at strobe");
            end else begin
                p = pq.pop_front();
                case (p.kind)
                    1:       got = (cake[p.slot] === 1'b1) ? 1 : 0;
                    2:       got = int'(active_count);
                    3:       got = (busy === 1'b1) ? 1 : 0;
                    default: got = ((|cake) === 1'b0) ? 0 : 1;
                endcase
                if (got != p.exp) begin
                    fails++;
                    $display("FAIL %s[%0d] tag=%0d got=%0d required=%0d",
                             kname(p.kind), p.slot, p.tag, got, p.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int kind, input int slot, input int px, input int py, input int exp);
        xLength = 10'(px);
        yLength = 10'(py);
        tag++;
        pq.push_back('{kind, slot, exp, tag});
        strobe = 1'b1;
        cyc(1);
        strobe = 1'b0;
    endtask

    task automatic pulse_tick(input bit accept, input int len);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        if (accept) begin
            model_sweep();
            sq.push_back(len);
        end
    endtask

    task automatic tick(input int gap, input bit accept);
        pulse_tick(accept, N);
        cyc(gap - 1);
    endtask

    initial begin
        model_reset();
        cyc(3);
        rst = 1'b1;
        cyc(2);

        // reset state
        probe(3, 0, 0, 0, 0);
        probe(2, 0, 0, 0, 0);
        probe(4, 0, 0, 0, 0);
        probe(4, 0, X0, 0, 0);
        probe(4, 0, 639, 479, 0);

        // first spawn on the fourth tick; seed gives x=78
        for (int i = 0; i < 3; i++) tick(200, 1);
        probe(2, 0, 0, 0, 0);
        probe(1, 0, X0, 0, 0);
        tick(200, 1);
        probe(2, 0, 0, 0, 1);
        probe(1, 0, X0, 0, 1);
        probe(1, 0, X0 + 7, 7, 1);
        probe(1, 0, X0 + 8, 0, 0);
        probe(1, 0, X0 - 1, 0, 0);
        probe(1, 0, X0, 8, 0);

        // fall to the bottom edge
        for (int i = 0; i < 239; i++) tick(110, 1);
        probe(1, 0, X0, 478, 1);
        probe(1, 0, X0, 477, 0);
        probe(2, 0, 0, 0, 60);
        pulse_tick(1, N);
        cyc(9);
        probe(2, 0, 0, 0, 59);
        cyc(100);
        probe(1, 0, X0, 478, 0);
        probe(2, 0, 0, 0, 60);

        // tick while busy is ignored
        pulse_tick(1, N);
        cyc(20);
        pulse_tick(0, N);
        cyc(100);
        probe(1, 1, mx[1], my[1], 1);
        probe(1, 1, mx[1], my[1] - 1, 0);
        probe(2, 0, 0, 0, mcount());

        // freeze mid-sweep, then frozen ticks
        pulse_tick(1, N);
        cyc(30);
        freeze = 1'b1;
        cyc(80);
        for (int i = 0; i < 8; i++) tick(110, 0);
        probe(2, 0, 0, 0, mcount());
        probe(1, 1, mx[1], my[1], 1);
        probe(1, 1, mx[1], my[1] + 8, 0);
        freeze = 1'b0;
        tick(110, 1);
        tick(110, 1);
        probe(1, last_spawn, mx[last_spawn], 0, 1);
        probe(1, last_spawn, mx[last_spawn] + 8, 0, 0);
        probe(2, 0, 0, 0, mcount());

        // reset at idx=50
        pulse_tick(1, 50);
        cyc(50);
        rst = 1'b0;
        probe(3, 0, 0, 0, 0);
        probe(4, 0, mx[1], my[1], 0);
        probe(2, 0, 0, 0, 0);
        cyc(2);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) tick(200, 1);
        probe(1, 0, X0, 0, 1);
        probe(1, 0, X0 + 8, 0, 0);
        probe(2, 0, 0, 0, 1);

        cyc(20);
        tests++;
        if (sq.size() != 0) begin
            fails++;
            $display("FAIL sweeps_missing got=%0d outstanding required=0", sq.size());
        end
        tests++;
        if (pq.size() != 0) begin
            fails++;
            $display("FAIL probes_unchecked got=%0d outstanding required=0", pq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
